// File: rtl/seg_scan_if.sv
// Host-side bundle for the seven-segment scan driver: value/mode inputs
// plus the digit code, anode strobes and handshake pulses it returns.
interface seg_scan_if;
  logic [15:0] Value;
  logic        Load;
  logic [1:0]  Mode;
  logic [3:0]  Blank_Mask;
  logic [4:0]  Digit;
  logic [3:0]  Anode;
  logic        Load_Ack;
  logic        Frame_Done;

  modport master (
    output Value, Load, Mode, Blank_Mask,
    input  Digit, Anode, Load_Ack, Frame_Done
  );

  modport slave (
    input  Value, Load, Mode, Blank_Mask,
    output Digit, Anode, Load_Ack, Frame_Done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode display scanner with guard blanking
// and frame-aligned commit of new values, mode and blank mask.
module seg_scan_driver #(
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned GUARD_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_scan_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [4:0] DIG_PROMPT = 5'd16;
  localparam logic [4:0] DIG_DASH   = 5'd17;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DWELL = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        digit_q, digit_d;
  logic [15:0]       value_q, value_d;
  logic [1:0]        mode_q, mode_d;
  logic [3:0]        mask_q, mask_d;
  logic [15:0]       pend_val_q, pend_val_d;
  logic              pend_q, pend_d;
  logic              ack_q, ack_d;
  logic              frame_done_q, frame_done_d;

  logic              dwell_end;
  logic              boundary;
  logic [3:0]        anode;

  function automatic logic [4:0] digit_code(input logic [15:0] val,
                                            input logic [1:0]  mode,
                                            input logic [1:0]  idx);
    logic [3:0] nib;
    nib = val[{idx, 2'b00} +: 4];
    case (mode)
      2'b01:   digit_code = DIG_DASH;
      2'b10:   digit_code = (idx == 2'd3) ? DIG_PROMPT : {1'b0, nib};
      default: digit_code = {1'b0, nib};
    endcase
  endfunction

  // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    digit_d      = digit_q;
    value_d      = value_q;
    mode_d       = mode_q;
    mask_d       = mask_q;
    pend_val_d   = pend_val_q;
    pend_d       = pend_q;
    ack_d        = 1'b0;
    frame_done_d = 1'b0;
    dwell_end    = 1'b0;
    boundary     = 1'b0;

    case (state_q)
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_DWELL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DWELL: begin
        if (cnt_q == DWELL_LAST) begin
          state_d   = ST_GUARD;
          cnt_d     = '0;
          idx_d     = idx_q + 2'd1;
          dwell_end = 1'b1;
          boundary  = (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_GUARD;
        cnt_d   = '0;
      end
    endcase

    // A load on the boundary edge itself bypasses the pending register.
    if (boundary) begin
      frame_done_d = 1'b1;
      mode_d       = bus.Mode;
      mask_d       = bus.Blank_Mask;
      pend_d       = 1'b0;
      if (bus.Load) begin
        value_d = bus.Value;
        ack_d   = 1'b1;
      end else if (pend_q) begin
        value_d = pend_val_q;
        ack_d   = 1'b1;
      end
    end else if (bus.Load) begin
      pend_val_d = bus.Value;
      pend_d     = 1'b1;
    end

    // Uses the freshly committed value/mode so idx 0 of a new frame is consistent.
    if (dwell_end) begin
      digit_d = digit_code(value_d, mode_d, idx_d);
    end
  end

  // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_GUARD;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      digit_q      <= 5'd0;
      value_q      <= 16'h0000;
      mode_q       <= 2'b00;
      mask_q       <= 4'b0000;
      pend_val_q   <= 16'h0000;
      pend_q       <= 1'b0;
      ack_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      value_q      <= value_d;
      mode_q       <= mode_d;
      mask_q       <= mask_d;
      pend_val_q   <= pend_val_d;
      pend_q       <= pend_d;
      ack_q        <= ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Anodes decode straight from state registers, so reset darkens them immediately.
  always_comb begin
    anode = 4'b1111;
    if (state_q == ST_DWELL && !mask_q[idx_q]) begin
      anode = ~(4'b0001 << idx_q);
    end
  end

  assign bus.Anode      = anode;
  assign bus.Digit      = digit_q;
  assign bus.Load_Ack   = ack_q;
  assign bus.Frame_Done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DWELL=4, GUARD=1 (20-cycle frames);
// every output is compared each cycle against hand-derived frame expectations.
module tb_seg_scan_driver;

  localparam int DW    = 4;
  localparam int GD    = 1;
  localparam int SLOT  = DW + GD;
  localparam int FRAME = 4 * SLOT;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  seg_scan_if bus ();

  seg_scan_driver #(
    .DWELL_CYCLES(DW),
    .GUARD_CYCLES(GD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] exp_digit(input logic [15:0] v, input logic [1:0] m, input int idx);
    logic [15:0] s;
    if (m == 2'b01) return 5'd17;
    if (m == 2'b10 && idx == 3) return 5'd16;
    s = v >> (4 * idx);
    return {1'b0, s[3:0]};
  endfunction

  function automatic logic [3:0] exp_anode(input int pos, input logic [3:0] mask);
    int idx;
    logic [3:0] a;
    idx = pos / SLOT;
    if (pos % SLOT == 0 || mask[idx]) return 4'b1111;
    a = 4'b0001 << idx;
    return ~a;
  endfunction

  // Starts just after a frame's first edge; leaves the bench at the next frame's start.
  task automatic run_frame(input string name, input logic [15:0] val, input logic [1:0] mode,
                           input logic [3:0] mask, input logic fd0, input logic ack0,
                           input int l1_pos, input logic [15:0] l1_val,
                           input int l2_pos, input logic [15:0] l2_val);
    for (int pos = 0; pos < FRAME; pos++) begin
      check($sformatf("%s anode p%0d", name, pos), bus.Anode, exp_anode(pos, mask));
      check($sformatf("%s digit p%0d", name, pos), bus.Digit, exp_digit(val, mode, pos / SLOT));
      check($sformatf("%s frame_done p%0d", name, pos), bus.Frame_Done, (pos == 0) ? fd0 : 1'b0);
      check($sformatf("%s load_ack p%0d", name, pos), bus.Load_Ack, (pos == 0) ? ack0 : 1'b0);
      if (pos == l1_pos) begin
        bus.Load  = 1'b1;
        bus.Value = l1_val;
      end else if (pos == l2_pos) begin
        bus.Load  = 1'b1;
        bus.Value = l2_val;
      end else begin
        bus.Load = 1'b0;
      end
      tick();
    end
    bus.Load = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.Value      = 16'h0000;
    bus.Load       = 1'b0;
    bus.Mode       = 2'b00;
    bus.Blank_Mask = 4'b0000;

    repeat (2) tick();
    check("rst anode", bus.Anode, 4'b1111);
    check("rst digit", bus.Digit, 5'd0);
    check("rst load_ack", bus.Load_Ack, 1'b0);
    check("rst frame_done", bus.Frame_Done, 1'b0);
    rst_n = 1'b1;

    // First frame after reset: no boundary pulse at its start, all zero digits.
    run_frame("f0", 16'h0000, 2'b00, 4'b0000, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);
    run_frame("f1", 16'h0000, 2'b00, 4'b0000, 1'b1, 1'b0, 7, 16'hA5C3, -1, 16'h0);
    run_frame("f2", 16'hA5C3, 2'b00, 4'b0000, 1'b1, 1'b1, 3, 16'h1111, 12, 16'h2222);
    run_frame("f3", 16'h2222, 2'b00, 4'b0000, 1'b1, 1'b1, 19, 16'h0F0F, -1, 16'h0);
    run_frame("f4", 16'h0F0F, 2'b00, 4'b0000, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0);

    // Mode change mid-frame must wait for the next boundary.
    bus.Mode = 2'b10;
    run_frame("f5", 16'h0F0F, 2'b00, 4'b0000, 1'b1, 1'b0, 5, 16'h1234, -1, 16'h0);
    bus.Mode       = 2'b01;
    bus.Blank_Mask = 4'b0101;
    run_frame("f6", 16'h1234, 2'b10, 4'b0000, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0);
    bus.Mode       = 2'b00;
    bus.Blank_Mask = 4'b0000;
    run_frame("f7", 16'h1234, 2'b01, 4'b0101, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);

    // Partial frame with a pending load, then reset in the middle of idx 1 dwell.
    for (int pos = 0; pos < 8; pos++) begin
      bus.Load  = (pos == 6);
      bus.Value = 16'hBEEF;
      tick();
    end
    bus.Load = 1'b0;
    check("f8 anode pre-reset", bus.Anode, 4'b1101);
    check("f8 digit pre-reset", bus.Digit, 5'd3);
    rst_n = 1'b0;
    #1;
    check("async rst anode", bus.Anode, 4'b1111);
    check("async rst digit", bus.Digit, 5'd0);
    check("async rst load_ack", bus.Load_Ack, 1'b0);
    check("async rst frame_done", bus.Frame_Done, 1'b0);
    tick();
    rst_n = 1'b1;

    // The dropped pending load must never be acknowledged or shown.
    run_frame("r0", 16'h0000, 2'b00, 4'b0000, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0);
    run_frame("r1", 16'h0000, 2'b00, 4'b0000, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
